// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage controller between the X/M and M/W latches
// Optional MEM_TIMEOUT_EN: abandon an access after MAX_WAIT unacknowledged wait cycles.
module mem_stage_ctrl #(
   parameter int ADDR_W   = 12,
   parameter int MAX_WAIT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              xmValid,
   input  logic [31:0]       oIn,
   input  logic [31:0]       dIn,
   input  logic [4:0]        rdIn,
   input  logic              wMemIn,
   input  logic              wRegIn,
   input  logic              lwIn,
   output logic              stall,
   output logic              memReq,
   output logic              memWE,
   output logic [ADDR_W-1:0] memAddr,
   output logic [31:0]       memData,
   input  logic              memAck,
   input  logic [31:0]       memQ,
   output logic              mwValid,
   output logic              wRegOut,
   output logic              lwOut,
   output logic [31:0]       oOut,
   output logic [31:0]       memOut,
   output logic [4:0]        rdOut,
   output logic              memErr
);

   typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_ST} stateT;

   stateT       state;
   logic [31:0] capO;
   logic [4:0]  capRd;
   logic        capWReg;
   logic        memOp;
   logic        waiting;
   logic        giveUp;

   assign memOp   = xmValid & (lwIn | wMemIn);
   assign waiting = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   logic [CNT_W-1:0] waitCnt;

   // waitCnt counts completed unacknowledged wait cycles; the limit cycle is the MAX_WAIT-th
   assign giveUp = waiting & ~memAck & (waitCnt == CNT_W'(MAX_WAIT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         waitCnt <= '0;
         memErr  <= 1'b0;
      end else begin
         if (!waiting)
            waitCnt <= '0;
         else if (!memAck)
            waitCnt <= waitCnt + CNT_W'(1);
         if (giveUp)
            memErr <= 1'b1;
      end
   end
`else
   assign giveUp = 1'b0;
   assign memErr = 1'b0;
`endif

   assign stall = waiting ? ~(memAck | giveUp) : memOp;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         memReq  <= 1'b0;
         memWE   <= 1'b0;
         memAddr <= '0;
         memData <= '0;
         capO    <= '0;
         capRd   <= '0;
         capWReg <= 1'b0;
         mwValid <= 1'b0;
         wRegOut <= 1'b0;
         lwOut   <= 1'b0;
         oOut    <= '0;
         memOut  <= '0;
         rdOut   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (memOp) begin
                  memAddr <= oIn[ADDR_W-1:0];
                  memData <= dIn;
                  memWE   <= wMemIn & ~lwIn;
                  capO    <= oIn;
                  capRd   <= rdIn;
                  capWReg <= wRegIn;
                  memReq  <= 1'b1;
                  mwValid <= 1'b0;
                  state   <= lwIn ? WAIT_LD : WAIT_ST;
               end else begin
                  mwValid <= xmValid;
                  oOut    <= oIn;
                  rdOut   <= rdIn;
                  wRegOut <= wRegIn & (rdIn != 5'd0);
                  lwOut   <= 1'b0;
               end
            end
            default: begin
               if (memAck) begin
                  state   <= IDLE;
                  memReq  <= 1'b0;
                  mwValid <= 1'b1;
                  oOut    <= capO;
                  rdOut   <= capRd;
                  if (state == WAIT_LD) begin
                     memOut  <= memQ;
                     lwOut   <= 1'b1;
                     wRegOut <= capWReg & (capRd != 5'd0);
                  end else begin
                     lwOut   <= 1'b0;
                     wRegOut <= 1'b0;
                  end
               end else if (giveUp) begin
                  // abandoned access retires as a harmless no-write instruction
                  state   <= IDLE;
                  memReq  <= 1'b0;
                  mwValid <= 1'b1;
                  oOut    <= capO;
                  rdOut   <= capRd;
                  wRegOut <= 1'b0;
                  lwOut   <= 1'b0;
                  memOut  <= 32'h0;
               end else begin
                  mwValid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
